// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package inst_mem_pkg;

    localparam int unsigned DEPTH_WORDS_DEFAULT = 256;
    localparam int unsigned INSTR_W             = 32;
    localparam int unsigned ADDR_W              = 64;
    localparam logic [INSTR_W-1:0] NOP_INSTR    = 32'h00000013;

    typedef enum logic [1:0] {
        FAULT_OK       = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fault_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        fault_e             fault;
    } rsp_entry_t;

    // Misalignment wins over out-of-range.
    function automatic fault_e classify(input logic [ADDR_W-1:0] addr,
                                        input int unsigned depth);
        if (addr[1:0] != 2'b00) begin
            return FAULT_MISALIGN;
        end
        if ({2'b00, addr[ADDR_W-1:2]} >= 64'(depth)) begin
            return FAULT_RANGE;
        end
        return FAULT_OK;
    endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Two-entry response buffer (instr + fault) with occupancy count.
module rsp_fifo
    import inst_mem_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       push_i,
    input  rsp_entry_t push_data_i,
    input  logic       pop_i,
    output rsp_entry_t head_o,
    output logic [1:0] count_o
);

    rsp_entry_t entry_q [2];
    logic       rd_ptr_q;
    logic       wr_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       do_push;
    logic       do_pop;

    always_comb begin
        do_pop  = pop_i && (count_q != 2'd0);
        do_push = push_i && ((count_q != 2'd2) || do_pop);
        count_d = count_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            entry_q[0] <= '0;
            entry_q[1] <= '0;
        end else begin
            if (do_push) begin
                entry_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign head_o  = entry_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction fetch responder: synchronous-read word memory, program-load port,
// and an in-order response path holding at most two outstanding fetches.
module inst_mem_responder
    import inst_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [1:0]  rsp_fault,
    input  logic        ld_valid,
    input  logic [63:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic        ld_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [INSTR_W-1:0] mem_q [DEPTH_WORDS];

    // Read stage: result of the fetch accepted at the previous edge.
    logic               rd_valid_q;
    logic [INSTR_W-1:0] rd_word_q;
    fault_e             rd_fault_q;

    logic               req_ready_q;
    logic               ld_err_q;

    logic               accept;
    logic               deliver;
    fault_e             req_fault;
    logic [AW-1:0]      rd_idx;
    logic [AW-1:0]      ld_idx;
    logic               ld_in_range;
    logic [1:0]         occ_q;
    logic [1:0]         occ_d;

    logic               fifo_push;
    logic               fifo_pop;
    rsp_entry_t         fifo_head;
    logic [1:0]         fifo_count;
    logic               head_from_fifo;

    always_comb begin
        req_fault      = classify(req_addr, DEPTH_WORDS);
        rd_idx         = req_addr[AW+1:2];
        ld_idx         = ld_addr[AW-1:0];
        ld_in_range    = (ld_addr < 64'(DEPTH_WORDS));
        head_from_fifo = (fifo_count != 2'd0);
        accept         = req_valid && req_ready_q;
        deliver        = rsp_valid && rsp_ready;
        fifo_pop       = deliver && head_from_fifo;
        // Park the read result unless it is the head being delivered right now.
        fifo_push      = rd_valid_q && !(deliver && !head_from_fifo);
        occ_q          = fifo_count + 2'(rd_valid_q);
        occ_d          = occ_q + 2'(accept) - 2'(deliver);
    end

    // Storage: loads write, fetches read the pre-write word at the same edge.
    always_ff @(posedge clock) begin
        if (reset && ld_valid && ld_in_range) begin
            mem_q[ld_idx] <= ld_data;
        end
        if (accept) begin
            rd_word_q <= (req_fault == FAULT_OK) ? mem_q[rd_idx] : NOP_INSTR;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_valid_q  <= 1'b0;
            rd_fault_q  <= FAULT_OK;
            req_ready_q <= 1'b0;
            ld_err_q    <= 1'b0;
        end else begin
            rd_valid_q <= accept;
            if (accept) begin
                rd_fault_q <= req_fault;
            end
            req_ready_q <= (occ_d < 2'd2);
            ld_err_q    <= ld_valid && !ld_in_range;
        end
    end

    rsp_fifo u_rsp_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i ('{instr: rd_word_q, fault: rd_fault_q}),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    // Buffered entries are older than the read stage, so they present first.
    always_comb begin
        rsp_valid = 1'b0;
        rsp_instr = '0;
        rsp_fault = FAULT_OK;
        if (head_from_fifo) begin
            rsp_valid = 1'b1;
            rsp_instr = fifo_head.instr;
            rsp_fault = fifo_head.fault;
        end else if (rd_valid_q) begin
            rsp_valid = 1'b1;
            rsp_instr = rd_word_q;
            rsp_fault = rd_fault_q;
        end
    end

    assign req_ready = req_ready_q;
    assign ld_err    = ld_err_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed self-checking bench for inst_mem_responder (DEPTH_WORDS = 256).
module tb_inst_mem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [1:0]  rsp_fault;
    logic        ld_valid;
    logic [63:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_err;

    int tests  = 0;
    int failed = 0;

    inst_mem_responder #(.DEPTH_WORDS(256)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_fault (rsp_fault),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_err    (ld_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic [31:0] instr, input logic [1:0] fault);
        chk({tag, ".valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, ".instr"}, 64'(rsp_instr), 64'(instr));
        chk({tag, ".fault"}, 64'(rsp_fault), 64'(fault));
    endtask

    task automatic load(input logic [63:0] a, input logic [31:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        tick();
        ld_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;

        // Reset state
        tick(); tick();
        chk("rst.req_ready", 64'(req_ready), 64'd0);
        chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst.rsp_instr", 64'(rsp_instr), 64'd0);
        chk("rst.rsp_fault", 64'(rsp_fault), 64'd0);
        chk("rst.ld_err",    64'(ld_err),    64'd0);

        reset = 1'b1;
        tick();
        chk("post_rst.req_ready", 64'(req_ready), 64'd1);

        // Program load
        for (int i = 0; i < 4; i++) load(64'(i), 32'hA0 + 32'(i));
        load(64'd5, 32'hAA);
        load(64'd10, 32'h1111);
        chk("ld_ok.ld_err", 64'(ld_err), 64'd0);
        load(64'd256, 32'hFF);
        chk("ld_oor.ld_err", 64'(ld_err), 64'd1);
        tick();
        chk("ld_oor.ld_err_drop", 64'(ld_err), 64'd0);

        // Load during reset is ignored, memory survives reset
        reset = 1'b0;
        load(64'd10, 32'h2222);
        chk("rst_ld.ld_err", 64'(ld_err), 64'd0);
        reset = 1'b1;
        tick();

        // Streaming fetch, one response per cycle
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = 64'(4 * i);
            tick();
            chk_rsp($sformatf("stream%0d", i), 32'hA0 + 32'(i), 2'b00);
            chk($sformatf("stream%0d.req_ready", i), 64'(req_ready), 64'd1);
        end
        req_valid = 1'b0;
        tick();
        chk("stream.drained", 64'(rsp_valid), 64'd0);

        // Fault classification and preserved memory
        req_valid = 1'b1;
        req_addr = 64'h6;    tick(); chk_rsp("misalign", 32'h13, 2'b01);
        req_addr = 64'd1024; tick(); chk_rsp("range",    32'h13, 2'b10);
        req_addr = 64'd1026; tick(); chk_rsp("both",     32'h13, 2'b01);
        req_addr = 64'd40;   tick(); chk_rsp("word10",   32'h1111, 2'b00);
        req_addr = 64'd0;    tick(); chk_rsp("word0_intact", 32'hA0, 2'b00);
        req_valid = 1'b0;
        tick();

        // Backpressure: two accepted, third refused, head stable
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr = 64'd0; tick();
        chk_rsp("bp1", 32'hA0, 2'b00);
        chk("bp1.req_ready", 64'(req_ready), 64'd1);
        req_addr = 64'd4; tick();
        chk_rsp("bp2", 32'hA0, 2'b00);
        chk("bp2.req_ready", 64'(req_ready), 64'd0);
        req_addr = 64'd8; tick();
        chk_rsp("bp3", 32'hA0, 2'b00);
        chk("bp3.req_ready", 64'(req_ready), 64'd0);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk_rsp("drain1", 32'hA1, 2'b00);
        chk("drain1.req_ready", 64'(req_ready), 64'd1);
        tick();
        chk("drain2.empty", 64'(rsp_valid), 64'd0);

        // Same-edge load and fetch: read-before-write
        req_valid = 1'b1; req_addr = 64'd20;
        ld_valid = 1'b1; ld_addr = 64'd5; ld_data = 32'hBB;
        tick();
        ld_valid = 1'b0;
        chk_rsp("rbw_old", 32'hAA, 2'b00);
        tick();
        chk_rsp("rbw_new", 32'hBB, 2'b00);
        req_valid = 1'b0;
        tick();

        // Reset mid-transfer discards outstanding responses
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr = 64'd0; tick();
        req_addr = 64'd4; tick();
        chk("mid.req_ready", 64'(req_ready), 64'd0);
        req_valid = 1'b0;
        reset = 1'b0;
        tick();
        chk("mid_rst.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst.req_ready", 64'(req_ready), 64'd0);
        reset = 1'b1;
        rsp_ready = 1'b1;
        tick();
        chk("after_rst.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("after_rst.req_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_addr = 64'd12;
        tick();
        chk_rsp("after_rst.fetch", 32'hA3, 2'b00);
        req_valid = 1'b0;
        tick();
        chk("after_rst.empty", 64'(rsp_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
